// File: rtl/wb_mem_slave_pkg.sv
// rtl/wb_mem_slave_pkg.sv - shared types and constants for the wishbone memory slave
// Contents: FSM state encoding, bus widths, stall-LFSR seed and feedback mask.
package wb_mem_slave_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      XFER = 2'd2,
      ERR  = 2'd3
   } state_t;

   localparam int WB_DATA_LEN = 32;
   localparam int WB_BL_W     = 10;

   // Right-shifting Fibonacci LFSR, polynomial x^16 + x^14 + x^13 + x^11 + 1.
   // With a right shift those taps land on bit positions 0, 2, 3 and 5.
   localparam logic [15:0] LFSR_SEED     = 16'hACE1;
   localparam logic [15:0] LFSR_TAP_MASK = 16'h002D;

endpackage

// File: rtl/wb_mem_slave_lfsr.sv
// rtl/wb_mem_slave_lfsr.sv - pseudo-random stall generator for the memory slave
// Ports: clk_i bus clock, rst_n async active-low reset (reseeds),
//        stall_o high when the slave should withhold the current beat.
module wb_mem_slave_lfsr
   import wb_mem_slave_pkg::*;
(
   input  logic clk_i,
   input  logic rst_n,
   output logic stall_o
);

   logic [15:0] lfsr;

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         lfsr <= LFSR_SEED;
      end else begin
         lfsr <= {^(lfsr & LFSR_TAP_MASK), lfsr[15:1]};
      end
   end

   assign stall_o = (lfsr[1:0] == 2'b00);

endmodule

// File: rtl/wb_mem_slave.sv
// rtl/wb_mem_slave.sv - wishbone slave memory responder with burst support
// Optional build macro: WB_MEM_SLAVE_RAND_STALL_EN adds LFSR-driven beat stalls in XFER.
// Ports: clk_i/rst_n clock and async active-low reset; wbd_*_i master request
//        (dat, byte adr, sel, bl burst length, bry burst-ready, we, cyc, stb);
//        wbd_dat_o read data, wbd_ack_o beat ack, wbd_lack_o last-beat ack,
//        wbd_err_o range error.
module wb_mem_slave
   import wb_mem_slave_pkg::*;
#(
   parameter int MEM_BYTES   = 65536,
   parameter int WAIT_CYCLES = 1,
   parameter int BL_W        = WB_BL_W,
   parameter int DATA_W      = WB_DATA_LEN
) (
   input  logic              clk_i,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] wbd_dat_i,
   input  logic [31:0]       wbd_adr_i,
   input  logic [3:0]        wbd_sel_i,
   input  logic [BL_W-1:0]   wbd_bl_i,
   input  logic              wbd_bry_i,
   input  logic              wbd_we_i,
   input  logic              wbd_cyc_i,
   input  logic              wbd_stb_i,
   output logic [DATA_W-1:0] wbd_dat_o,
   output logic              wbd_ack_o,
   output logic              wbd_lack_o,
   output logic              wbd_err_o
);

   localparam int MEM_WORDS = MEM_BYTES / 4;
   localparam int ADR_W     = $clog2(MEM_BYTES);
   // One extra bit so the running word index can reach MEM_WORDS and be caught.
   localparam int WORD_W    = ADR_W - 1;
   localparam logic [WORD_W-1:0] WORD_END  = WORD_W'(MEM_WORDS);
   localparam logic [3:0]        WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   state_t            state, state_nxt;
   logic [WORD_W-1:0] word_q;
   logic [BL_W-1:0]   remaining_q;
   logic [3:0]        wait_q;
   logic              we_q;

   logic              req, adr_oob, word_oob, last_beat, beat, stall, mem_we;
   logic [WORD_W-2:0] mem_idx;
   logic [DATA_W-1:0] mem [MEM_WORDS];
   logic              unused_adr_lsbs;

   assign unused_adr_lsbs = ^wbd_adr_i[1:0];

`ifdef WB_MEM_SLAVE_RAND_STALL_EN
   wb_mem_slave_lfsr u_lfsr (
      .clk_i   (clk_i),
      .rst_n   (rst_n),
      .stall_o (stall)
   );
`else
   assign stall = 1'b0;
`endif

   assign req       = wbd_cyc_i & wbd_stb_i;
   assign adr_oob   = |wbd_adr_i[31:ADR_W];
   assign word_oob  = (word_q == WORD_END);
   assign last_beat = (remaining_q == BL_W'(1));
   // A random stall looks exactly like the master holding bry low.
   assign beat      = (state == XFER) & req & wbd_bry_i & ~stall;
   assign mem_idx   = word_q[WORD_W-2:0];
   assign mem_we    = beat & ~word_oob & we_q;

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (req) begin
               if (adr_oob)              state_nxt = ERR;
               else if (WAIT_CYCLES > 0) state_nxt = WAIT;
               else                      state_nxt = XFER;
            end
         end
         WAIT: begin
            if (!wbd_cyc_i)          state_nxt = IDLE;
            else if (wait_q == WAIT_LAST) state_nxt = XFER;
         end
         XFER: begin
            if (!wbd_cyc_i)                      state_nxt = IDLE;
            else if (beat && (word_oob || last_beat)) state_nxt = IDLE;
         end
         ERR:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      wbd_ack_o  = 1'b0;
      wbd_lack_o = 1'b0;
      wbd_err_o  = 1'b0;
      wbd_dat_o  = '0;
      case (state)
         XFER: begin
            if (beat) begin
               if (word_oob) begin
                  wbd_err_o = 1'b1;
               end else begin
                  wbd_ack_o  = 1'b1;
                  wbd_lack_o = last_beat;
                  if (!we_q) wbd_dat_o = mem[mem_idx];
               end
            end
         end
         ERR:     wbd_err_o = req;
         default: ;
      endcase
   end

   // Beat counter, wait counter and running word address.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         word_q      <= '0;
         remaining_q <= '0;
         wait_q      <= '0;
         we_q        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  word_q      <= {1'b0, wbd_adr_i[ADR_W-1:2]};
                  we_q        <= wbd_we_i;
                  remaining_q <= (wbd_bl_i == '0) ? BL_W'(1) : wbd_bl_i;
                  wait_q      <= '0;
               end
            end
            WAIT: wait_q <= wait_q + 4'd1;
            XFER: begin
               if (beat && !word_oob) begin
                  word_q      <= word_q + WORD_W'(1);
                  remaining_q <= remaining_q - BL_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // The array is deliberately left out of reset so contents survive rst_n pulses.
   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (wbd_sel_i[i]) mem[mem_idx][8*i +: 8] <= wbd_dat_i[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_wb_mem_slave.sv
// tb/tb_wb_mem_slave.sv - self-checking bench for wb_mem_slave
module tb_wb_mem_slave;

   localparam int W     = 1;
   localparam int MEMB  = 65536;
   localparam int WORDS = MEMB / 4;
   localparam logic [63:0] ONES = '1;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] dat_i, adr_i, dat_o;
   logic [3:0]  sel_i;
   logic [9:0]  bl_i;
   logic        bry_i, we_i, cyc_i, stb_i, ack_o, lack_o, err_o;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] ref_mem [WORDS];
   bit          ref_ok  [WORDS];

   always #5 clk = ~clk;

   wb_mem_slave #(.MEM_BYTES(MEMB), .WAIT_CYCLES(W), .BL_W(10), .DATA_W(32)) dut (
      .clk_i(clk), .rst_n(rst_n),
      .wbd_dat_i(dat_i), .wbd_adr_i(adr_i), .wbd_sel_i(sel_i), .wbd_bl_i(bl_i),
      .wbd_bry_i(bry_i), .wbd_we_i(we_i), .wbd_cyc_i(cyc_i), .wbd_stb_i(stb_i),
      .wbd_dat_o(dat_o), .wbd_ack_o(ack_o), .wbd_lack_o(lack_o), .wbd_err_o(err_o)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_write(input int w, input logic [3:0] sel, input logic [31:0] d);
      for (int i = 0; i < 4; i++) begin
         if (sel[i]) ref_mem[w][8*i +: 8] = d[8*i +: 8];
      end
      if (sel == 4'hF) ref_ok[w] = 1'b1;
   endtask

   // One request followed by its data phase. Beat i writes wdata + i*0x01010101.
   task automatic do_xfer(input logic [31:0] adr, input int bl, input logic we,
                          input logic [3:0] sel, input logic [31:0] wdata,
                          input logic [63:0] bry_pat, input int abort_after,
                          output int n_ack, output int n_err, output int first_ack,
                          output int last_cyc, output logic [31:0] first_rdat);
      int  n, b, w;
      bit  done;
      n = (bl == 0) ? 1 : bl;
      n_ack = 0; n_err = 0; first_ack = -1; last_cyc = -1; first_rdat = '0;
      b = 0; done = 0;
      @(negedge clk);
      cyc_i = 1; stb_i = 1; adr_i = adr; we_i = we; sel_i = sel;
      bl_i = 10'(bl); dat_i = wdata; bry_i = bry_pat[0];
      #1;
      check("idle_quiet", {ack_o, err_o}, 0);
      for (int c = 1; c < 300 && !done; c++) begin
         @(negedge clk);
         bry_i = (c < 64) ? bry_pat[c] : 1'b1;
         dat_i = wdata + 32'(b) * 32'h01010101;
         if (abort_after >= 0 && n_ack == abort_after) begin
            cyc_i = 0; stb_i = 0;
         end
         #1;
         w = int'(adr >> 2) + b;
         if (!cyc_i) begin
            check("abort_quiet", {ack_o, lack_o, err_o}, 0);
            done = 1;
         end else if (adr >= MEMB) begin
            check("range_err", err_o, 1);
            check("range_no_ack", ack_o, 0);
            n_err += int'(err_o);
            done = 1;
         end else if (ack_o || err_o) begin
            check("no_beat_in_wait", 32'(c > W), 1);
            check("beat_needs_bry", bry_i, 1);
            if (w >= WORDS) begin
               check("boundary_err", {ack_o, err_o}, 2'b01);
               n_err += int'(err_o);
               done = 1;
            end else begin
               check("beat_ack", {ack_o, err_o}, 2'b10);
               check("beat_lack", lack_o, 32'(b == n - 1));
               if (!we && ref_ok[w]) check("read_data", dat_o, ref_mem[w]);
               if (b == 0) first_rdat = dat_o;
               if (we) model_write(w, sel, dat_i);
               if (first_ack < 0) first_ack = c;
               n_ack++;
               b++;
               if (b == n) begin
                  done = 1;
                  last_cyc = c;
               end
            end
         end else begin
            check("idle_dat_zero", dat_o, 0);
`ifndef WB_MEM_SLAVE_RAND_STALL_EN
            if (c > W && bry_i) check("beat_missing", 0, 1);
`endif
         end
      end
      if (!done) check("xfer_timeout", 0, 1);
   endtask

   task automatic bus_idle();
      @(negedge clk);
      cyc_i = 0; stb_i = 0; bry_i = 0; we_i = 0;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst_n = 0; cyc_i = 0; stb_i = 0; bry_i = 0;
      @(negedge clk);
      rst_n = 1;
      repeat (2) @(negedge clk);
   endtask

   typedef struct {
      logic [31:0] adr;
      int          bl;
      logic        we;
      logic [3:0]  sel;
      logic [31:0] wdata;
      logic [63:0] bry_pat;
      int          abort_after;
      int          exp_acks;
      int          exp_err;
      logic        chk_rdat;
      logic [31:0] exp_rdat;
   } vec_t;

   vec_t vecs [15];

   initial begin
      int na, ne, fa, lc, lc1, lc2;
      logic [31:0] rd;

      vecs[0]  = '{32'h100,   1, 1'b1, 4'hF, 32'hDEADBEEF, ONES, -1, 1, 0, 1'b0, 32'h0};
      vecs[1]  = '{32'h100,   1, 1'b0, 4'h0, 32'h0,        ONES, -1, 1, 0, 1'b1, 32'hDEADBEEF};
      vecs[2]  = '{32'h200,   1, 1'b1, 4'hF, 32'h11223344, ONES, -1, 1, 0, 1'b0, 32'h0};
      vecs[3]  = '{32'h200,   1, 1'b1, 4'h5, 32'hAABBCCDD, ONES, -1, 1, 0, 1'b0, 32'h0};
      vecs[4]  = '{32'h200,   1, 1'b0, 4'h3, 32'h0,        ONES, -1, 1, 0, 1'b1, 32'h11BB33DD};
      vecs[5]  = '{32'h0,     4, 1'b1, 4'hF, 32'hA0000000, ONES, -1, 4, 0, 1'b0, 32'h0};
      vecs[6]  = '{32'h0,     4, 1'b0, 4'hF, 32'h0, 64'hFFFF_FFFF_FFFF_FFE7, -1, 4, 0, 1'b1, 32'hA0000000};
      vecs[7]  = '{32'h10000, 1, 1'b0, 4'hF, 32'h0,        ONES, -1, 0, 1, 1'b0, 32'h0};
      vecs[8]  = '{32'hFFFC,  3, 1'b1, 4'hF, 32'h5555AAAA, ONES, -1, 1, 1, 1'b0, 32'h0};
      vecs[9]  = '{32'hFFFC,  3, 1'b0, 4'hF, 32'h0,        ONES, -1, 1, 1, 1'b1, 32'h5555AAAA};
      vecs[10] = '{32'h300,   8, 1'b1, 4'hF, 32'h30000000, ONES, -1, 8, 0, 1'b0, 32'h0};
      vecs[11] = '{32'h300,   8, 1'b1, 4'hF, 32'hC0000000, ONES,  2, 2, 0, 1'b0, 32'h0};
      vecs[12] = '{32'h300,   8, 1'b0, 4'hF, 32'h0,        ONES, -1, 8, 0, 1'b1, 32'hC0000000};
      vecs[13] = '{32'h400,   0, 1'b1, 4'hF, 32'h12345678, ONES, -1, 1, 0, 1'b0, 32'h0};
      vecs[14] = '{32'h400,   1, 1'b0, 4'hF, 32'h0,        ONES, -1, 1, 0, 1'b1, 32'h12345678};

      rst_n = 0; cyc_i = 1; stb_i = 1; bry_i = 1; we_i = 0;
      adr_i = 0; dat_i = 0; sel_i = 4'hF; bl_i = 10'd1;
      #1;
      check("rst_ack", ack_o, 0);
      check("rst_lack", lack_o, 0);
      check("rst_err", err_o, 0);
      check("rst_dat", dat_o, 0);
      repeat (2) @(negedge clk);
      cyc_i = 0; stb_i = 0; bry_i = 0;
      rst_n = 1;
      @(negedge clk);

      for (int i = 0; i < 15; i++) begin
         do_xfer(vecs[i].adr, vecs[i].bl, vecs[i].we, vecs[i].sel, vecs[i].wdata,
                 vecs[i].bry_pat, vecs[i].abort_after, na, ne, fa, lc, rd);
         check($sformatf("vec%0d_acks", i), na, vecs[i].exp_acks);
         check($sformatf("vec%0d_err", i), ne, vecs[i].exp_err);
         if (vecs[i].chk_rdat) check($sformatf("vec%0d_rdat", i), rd, vecs[i].exp_rdat);
`ifndef WB_MEM_SLAVE_RAND_STALL_EN
         if (vecs[i].exp_acks > 0 && vecs[i].bry_pat == ONES)
            check($sformatf("vec%0d_latency", i), fa, 1 + W);
`endif
      end
      bus_idle();

      // Reset in the middle of a read burst: outputs drop at once, memory survives.
      do_xfer(32'h800, 4, 1'b1, 4'hF, 32'h80000000, ONES, -1, na, ne, fa, lc, rd);
      @(negedge clk);
      cyc_i = 1; stb_i = 1; bry_i = 1; we_i = 0; adr_i = 32'h800; bl_i = 10'd4;
      na = 0;
      for (int c = 0; c < 40 && na < 2; c++) begin
         @(negedge clk);
         #1;
         if (ack_o) na++;
      end
      check("rst_seq_acks", na, 2);
      @(negedge clk);
      rst_n = 0;
      #1;
      check("midrst_ack", ack_o, 0);
      check("midrst_lack", lack_o, 0);
      check("midrst_err", err_o, 0);
      check("midrst_dat", dat_o, 0);
      @(negedge clk);
      cyc_i = 0; stb_i = 0; bry_i = 0;
      rst_n = 1;
      do_xfer(32'h800, 4, 1'b0, 4'hF, 32'h0, ONES, -1, na, ne, fa, lc, rd);
      check("post_rst_acks", na, 4);
      check("post_rst_rdat", rd, 32'h80000000);
      bus_idle();

      // Randomised traffic against the array model.
      for (int t = 0; t < 40; t++) begin
         logic [31:0] a;
         logic [63:0] bp;
         int bl, n, avail, ea, ee;
         int r;
         r = $urandom_range(0, 9);
         if (r < 8)       a = 32'h2000 + 32'($urandom_range(0, 63)) * 4;
         else if (r == 8) a = 32'hFFF0 + 32'($urandom_range(0, 3)) * 4;
         else             a = 32'h10000 + 32'($urandom_range(0, 15)) * 4;
         bl = $urandom_range(0, 6);
         bp = {$urandom, $urandom} | {$urandom, $urandom};
         n  = (bl == 0) ? 1 : bl;
         if (a >= MEMB) begin
            ea = 0; ee = 1;
         end else begin
            avail = WORDS - int'(a >> 2);
            ea = (n < avail) ? n : avail;
            ee = (n > avail) ? 1 : 0;
         end
         do_xfer(a, bl, 1'($urandom_range(0, 1)), 4'($urandom), $urandom, bp, -1,
                 na, ne, fa, lc, rd);
         check($sformatf("rnd%0d_acks", t), na, ea);
         check($sformatf("rnd%0d_err", t), ne, ee);
      end
      bus_idle();

      // 64-beat burst read, run twice from an identical post-reset point.
      do_xfer(32'h1000, 64, 1'b1, 4'hF, 32'h01000000, ONES, -1, na, ne, fa, lc, rd);
      check("b64_wr_acks", na, 64);
      pulse_reset();
      do_xfer(32'h1000, 64, 1'b0, 4'hF, 32'h0, ONES, -1, na, ne, fa, lc1, rd);
      check("b64_rd_acks", na, 64);
      check("b64_rdat", rd, 32'h01000000);
      pulse_reset();
      do_xfer(32'h1000, 64, 1'b0, 4'hF, 32'h0, ONES, -1, na, ne, fa, lc2, rd);
      check("b64_rd2_acks", na, 64);
      check("b64_deterministic", lc2, lc1);
`ifdef WB_MEM_SLAVE_RAND_STALL_EN
      check("b64_stalled", 32'(lc1 > 64), 1);
`else
      check("b64_cycles", lc1, 64 + W);
`endif
      bus_idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
